id_ex_stage: RTL

Parametrised ID/EX pipeline stage carrying a decoded instruction, its address, two operands, destination register address and write enable from decode to execute. It is the successor of the fixed 16-bit ID/EX flop bank and adds a valid/ready handshake, back-pressure (stall) holding, and synchronous flush that drains the stage to a bubble. An optional two-entry skid buffer breaks the combinational ready path for timing.

---
 rtl/id_ex_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: valid/ready handshake, stall hold, synchronous flush to a bubble.
// Define ID_EX_SKID_EN to build the two-entry skid variant whose in_ready is a flop output.
`ifndef NOP
`define NOP 'h0001
`endif

module id_ex_stage #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 7,
  parameter int                RADDR_W  = 3,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(`NOP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  inst_i,
  input  logic [ADDR_W-1:0]  inst_addr_i,
  input  logic [DATA_W-1:0]  op1_i,
  input  logic [DATA_W-1:0]  op2_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               reg_wen_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  inst_o,
  output logic [ADDR_W-1:0]  inst_addr_o,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               reg_wen_o
);

  typedef struct packed {
    logic [DATA_W-1:0]  inst;
    logic [ADDR_W-1:0]  inst_addr;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_wen;
  } beat_t;

  // NOTE: payload registers are reset (not just the valid bits) because an empty
  // stage must present the bubble, so a stray reg_wen can never reach execute.
  localparam beat_t BUBBLE = '{NOP_INST, ADDR_W'(0), DATA_W'(0), DATA_W'(0), RADDR_W'(0), 1'b0};

  beat_t in_beat;
  beat_t main_q;
  logic  main_valid;
  logic  in_xfer;

  assign in_beat   = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
  assign out_valid = main_valid;
  assign {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = main_q;
  assign in_xfer   = in_valid && in_ready;

`ifdef ID_EX_SKID_EN
  beat_t skid_q;
  logic  skid_valid;

  // Ready comes straight from a flop, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let main_q see skid_q's new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_q     <= BUBBLE;
      skid_valid <= 1'b0;
      skid_q     <= BUBBLE;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_q     <= BUBBLE;
      skid_valid <= 1'b0;
      skid_q     <= BUBBLE;
    end else if (!main_valid || out_ready) begin
      // Main slot frees up: the older skid beat always goes first.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_q     <= skid_q;
        skid_valid <= 1'b0;
        skid_q     <= BUBBLE;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_q     <= in_beat;
      end else begin
        main_valid <= 1'b0;
        main_q     <= BUBBLE;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_q     <= in_beat;
    end
  end
`else
  logic out_xfer;

  assign out_xfer = main_valid && out_ready;
  assign in_ready = !main_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_q     <= BUBBLE;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_q     <= BUBBLE;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_q     <= in_beat;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
      main_q     <= BUBBLE;
    end
  end
`endif

endmodule
